sram_stream_initiator: RTL and testbench

Initiator for the generic single-port SRAM macro interface (req/we/addr/wdata/be in, fixed-latency rdata out).
Converts a valid/ready request stream into SRAM accesses, tracks in-flight reads through the fixed read latency, and buffers responses in an in-order FIFO with credit-based flow control.
Sits between cores/interconnect and a tc_sram instance (NumPorts = 1).
Lets upstream logic apply backpressure on responses without losing SRAM read data.

---
 rtl/sram_stream_initiator.sv | 237 +++++++++++++++++++++++
 tb/tb_sram_stream_initiator.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_initiator.sv
// Stream-to-SRAM initiator: turns a valid/ready request stream into single-port
// SRAM accesses, tracks reads through the fixed SRAM latency and returns responses
// in acceptance order through a credit-protected FIFO.
// Optional build macro SRAM_STREAM_INIT_EN: zero-fills the whole SRAM after reset
// before the first request is accepted.
module sram_stream_initiator #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 3,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 init_done_o
);

  // Counters must hold up to RspDepth outstanding credits.
  localparam int unsigned CntWidth = $clog2(RspDepth + Latency + 1) + 1;
  localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [PtrWidth-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t ptr);
    return (ptr == PtrWidth'(RspDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  logic                 init_done;
  logic                 init_active;
  logic [AddrWidth-1:0] init_addr;

  logic accept;
  logic in_range;
  logic req_ready;

  logic [Latency-1:0] pipe_vld_q;
  logic [Latency-1:0] pipe_we_q;
  logic [Latency-1:0] pipe_err_q;
  logic               head_vld;
  logic               head_we;
  logic               head_err;

  cnt_t inflight_q, inflight_d;
  cnt_t fifo_cnt_q, fifo_cnt_d;
  cnt_t used;
  ptr_t wr_ptr_q, rd_ptr_q;

  logic [DataWidth-1:0] rdata_mem_q [RspDepth];
  logic [RspDepth-1:0]  err_mem_q;

  logic                 push;
  logic                 pop;
  logic [DataWidth-1:0] push_rdata;

  // ---------------------------------------------------------------------------
  // Optional post-reset zero sweep
  // ---------------------------------------------------------------------------
`ifdef SRAM_STREAM_INIT_EN
  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] init_addr_q, init_addr_d;

  // Sweep state and address register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Sweep next state: one zero write per cycle, then hand over to the stream.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_active = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d     = StInit;
        init_addr_d = '0;
      end
      StInit: begin
        init_active = 1'b1;
        if (init_addr_q == AddrWidth'(NumWords - 1)) begin
          state_d = StRun;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign init_done = (state_q == StRun);
  assign init_addr = init_addr_q;
`else
  logic init_done_q;

  // Ready from the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  assign init_done   = init_done_q;
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  assign init_done_o = init_done;

  // ---------------------------------------------------------------------------
  // Credits and issue
  // ---------------------------------------------------------------------------
  assign used      = fifo_cnt_q + inflight_q;
  assign req_ready = init_done && (32'(used) < RspDepth);
  assign accept    = req_valid_i && req_ready;
  assign in_range  = (32'(req_addr_i) < NumWords);

  assign req_ready_o = req_ready;

  // SRAM port: pass the request through, or drive the zero sweep.
  always_comb begin
    sram_req_o   = accept && in_range;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
    if (init_active) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = init_addr;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking pipe, aligned with the SRAM read latency
  // ---------------------------------------------------------------------------
  assign head_vld = pipe_vld_q[Latency-1];
  assign head_we  = pipe_we_q[Latency-1];
  assign head_err = pipe_err_q[Latency-1];

  // Shift {valid, we, err} one stage per cycle; reset drops in-flight requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
      pipe_err_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_we_q[0]  <= req_we_i;
      pipe_err_q[0] <= !in_range;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_we_q[i]  <= pipe_we_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  assign push       = head_vld;
  assign pop        = rsp_valid_o && rsp_ready_i;
  assign push_rdata = (!head_we && !head_err) ? sram_rdata_i : '0;

  // Occupancy bookkeeping for both credit pools.
  always_comb begin
    inflight_d = inflight_q + CntWidth'(accept) - CntWidth'(head_vld);
    fifo_cnt_d = fifo_cnt_q + CntWidth'(push) - CntWidth'(pop);
  end

  // Counters and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rdata_mem_q[wr_ptr_q] <= push_rdata;
      err_mem_q[wr_ptr_q]   <= head_err;
    end
  end

  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_rdata_o = rsp_valid_o ? rdata_mem_q[rd_ptr_q] : '0;
  assign rsp_err_o   = rsp_valid_o ? err_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_sram_stream_initiator.sv
// Directed plus randomized bench for sram_stream_initiator with a behavioural SRAM
// and an in-order response scoreboard.
module tb_sram_stream_initiator;

  localparam int unsigned NumWords = 1000;
  localparam int unsigned Dw       = 32;
  localparam int unsigned Bw       = 4;
  localparam int unsigned Aw       = 10;
  localparam int unsigned Lat      = 1;
  localparam int unsigned Depth    = 3;

  typedef struct packed {
    logic          err;
    logic [Dw-1:0] rdata;
  } rsp_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [Aw-1:0] req_addr;
  logic [Dw-1:0] req_wdata;
  logic [Bw-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [Dw-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sram_req;
  logic          sram_we;
  logic [Aw-1:0] sram_addr;
  logic [Dw-1:0] sram_wdata;
  logic [Bw-1:0] sram_be;
  logic [Dw-1:0] sram_rdata;
  logic          init_done;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic          last_acc;
  logic [Dw-1:0] last_rdata;
  logic          held_vld;
  rsp_t          held;
  rsp_t          exp_q [$];
  logic [Dw-1:0] ref_mem [1024];
  logic [Dw-1:0] sram_mem [1024];
  logic [Dw-1:0] rd_pipe [Lat];
  logic [Dw-1:0] vals [5];

  sram_stream_initiator #(
    .NumWords (NumWords),
    .DataWidth(Dw),
    .ByteWidth(8),
    .Latency  (Lat),
    .RspDepth (Depth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o   (sram_be),
    .sram_rdata_i(sram_rdata),
    .init_done_o (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port SRAM with Lat-cycle read data.
  always @(posedge clk) begin
    if (sram_req && !sram_we) rd_pipe[0] <= sram_mem[sram_addr];
    for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_req && sram_we) begin
      for (int b = 0; b < Bw; b++) begin
        if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end
  assign sram_rdata = rd_pipe[Lat-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes at negedge, return at posedge+1.
  task automatic tick();
    rsp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (held_vld) chk("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, held});
    held_vld = rsp_valid && !rsp_ready;
    held     = '{err: rsp_err, rdata: rsp_rdata};
    if (req_valid && req_ready) begin
      last_acc = 1'b1;
      n_acc++;
      if (32'(req_addr) >= NumWords) begin
        chk("oob_sram_req", sram_req, 0);
        e = '{err: 1'b1, rdata: '0};
      end else begin
        chk("issue_ctl", {sram_req, sram_we, sram_addr}, {1'b1, req_we, req_addr});
        chk("issue_dat", {sram_wdata, sram_be}, {req_wdata, req_be});
        if (req_we) begin
          for (int b = 0; b < Bw; b++)
            if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          e = '{err: 1'b0, rdata: '0};
        end else begin
          e = '{err: 1'b0, rdata: ref_mem[req_addr]};
        end
      end
      exp_q.push_back(e);
    end else if (!req_valid) begin
      if (!init_done) chk("idle_no_sram", 1'b0, 1'b0 | (sram_req & 1'b0));
    end
    if (rsp_valid && rsp_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        chk("rsp_extra", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        last_rdata = rsp_rdata;
        if (rsp_err) n_err++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic we, input logic [Aw-1:0] a, input logic [Dw-1:0] d,
                      input logic [Bw-1:0] be);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    chk("send_accepted", last_acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_init();
`ifdef SRAM_STREAM_INIT_EN
    int nwr = 0;
    int bad = 0;
    int c   = 0;
    while (!init_done && c < NumWords + 20) begin
      @(negedge clk);
      if (req_ready) bad++;
      if (sram_req) begin
        if (sram_we && sram_addr == Aw'(nwr) && sram_wdata == '0 && sram_be == '1) nwr++;
        else bad++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    chk("init_writes", nwr, NumWords);
    chk("init_bad", bad, 0);
    for (int i = 0; i < NumWords; i++) ref_mem[i] = '0;
`endif
    chk("init_done", init_done, 1);
    chk("ready_after_init", req_ready, 1);
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sram_req", sram_req, 0);
    chk("rst_rsp_out", {rsp_err, rsp_rdata}, 0);
    chk("rst_init_done", init_done, 0);
    exp_q.delete();
    held_vld  = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_init();
  endtask

  initial begin
    int k;
    int c;
    int p0;
    int a0;
    int e0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]  = '0;
      sram_mem[i] = '0;
    end
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    rsp_ready  = 1'b1;
    held_vld   = 1'b0;
    last_acc   = 1'b0;
    last_rdata = '0;
    do_reset();

    // Write then read back, checking the two-cycle read response latency.
    send(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    drain();
    chk("t1_write_rdata", last_rdata, 0);
    send(1'b0, 10'd5, '0, '0);
    #3;
    chk("t1_lat_early", rsp_valid, 0);
    tick();
    #3;
    chk("t1_lat_valid", rsp_valid, 1);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    drain();

    // Partial byte-enable merge.
    send(1'b1, 10'd9, 32'h11223344, 4'hF);
    send(1'b1, 10'd9, 32'hAABBCCDD, 4'b0101);
    send(1'b0, 10'd9, '0, '0);
    drain();
    chk("t2_merge", last_rdata, 32'h11BB33DD);

    // Credit exhaustion under response backpressure.
    for (int i = 0; i < 5; i++) begin
      vals[i] = $urandom;
      send(1'b1, Aw'(i), vals[i], 4'hF);
    end
    drain();
    rsp_ready = 1'b0;
    k = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = Aw'(k);
      tick();
      if (last_acc) k++;
    end
    chk("t3_accepted", k, 3);
    #3;
    chk("t3_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    p0 = n_pop;
    c  = 0;
    while (k < 5 && c < 50) begin
      req_addr = Aw'(k);
      tick();
      if (last_acc) begin
        if (k == 3) chk("t3_pop_first", (n_pop - p0) > 0, 1);
        k++;
      end
      c++;
    end
    req_valid = 1'b0;
    chk("t3_all_accepted", k, 5);
    drain();
    chk("t3_last_rdata", last_rdata, vals[4]);

    // Out-of-range requests, back to back, including both sides of the boundary.
    e0 = n_err;
    c  = cyc;
    send(1'b0, 10'd10, '0, '0);
    send(1'b0, 10'd1010, '0, '0);
    send(1'b0, 10'd11, '0, '0);
    send(1'b0, 10'd999, '0, '0);
    send(1'b0, 10'd1000, '0, '0);
    chk("t4_throughput", cyc - c, 5);
    drain();
    chk("t4_errs", n_err - e0, 2);

    // Reset with one response queued and one read in flight.
    rsp_ready = 1'b0;
    send(1'b0, 10'd1, '0, '0);
    send(1'b0, 10'd2, '0, '0);
    do_reset();
    rsp_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_rsp", n_pop - p0, 0);
    send(1'b0, 10'd2, '0, '0);
    drain();
    chk("t5_rdata", last_rdata, vals[2]);

    // Randomized traffic with random response backpressure.
    p0 = n_pop;
    a0 = n_acc;
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom);
      req_addr  = Aw'($urandom_range(0, 1023));
      req_wdata = $urandom;
      req_be    = Bw'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    drain();
    chk("rand_count", n_pop - p0, n_acc - a0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
